// File: rtl/colour_classifier.sv
// colour_classifier: drives the colour sensor filter selects, measures the
// high-pulse width under each filter, votes each window's sample against
// per-class threshold windows and issues a one-hot colour decision per frame.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | stopped; votes cleared, outputs hold their last decision
// SETTLE  | filter just switched; input ignored for SETTLE_CYCLES cycles
// MEASURE | WIN_CYCLES-cycle window measuring high-pulse width
// DECIDE  | one cycle; pick winning class, publish colour, clear votes
module colour_classifier #(
  parameter int CNT_W         = 20,
  parameter int WIN_CYCLES    = 78125,
  parameter int SETTLE_CYCLES = 1000,
  parameter int ROUNDS        = 16,
  parameter int NUM_CLASSES   = 3,
  parameter int MATCH_MIN     = 48
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           colour_freq,
  input  logic [NUM_CLASSES*4*CNT_W-1:0] thr_lo,
  input  logic [NUM_CLASSES*4*CNT_W-1:0] thr_hi,
  output logic                           s2,
  output logic                           s3,
  output logic [NUM_CLASSES-1:0]         colour,
  output logic                           result_valid,
  output logic                           no_signal,
  output logic [CNT_W-1:0]               sample,
  output logic [1:0]                     sample_filter,
  output logic                           sample_valid
);

  localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int VOTE_W  = $clog2(4 * ROUNDS + 1);
  localparam int RND_W   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int IDX_W   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  WIN_LOAD    = TMR_W'(WIN_CYCLES - 1);
  localparam logic [RND_W-1:0]  LAST_ROUND  = RND_W'(ROUNDS - 1);
  localparam logic [VOTE_W-1:0] MATCH_V     = VOTE_W'(MATCH_MIN);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DECIDE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              f_q, f_d;
  logic [RND_W-1:0]        round_q, round_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [1:0]              sync_q, sync_d;
  logic                    prev_q, prev_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        latch_q, latch_d;
  logic                    fall_seen_q, fall_seen_d;
  logic                    miss_q, miss_d;
  logic [VOTE_W-1:0]       vote_q [NUM_CLASSES];
  logic [VOTE_W-1:0]       vote_d [NUM_CLASSES];
  logic                    s2_q, s2_d, s3_q, s3_d;
  logic [NUM_CLASSES-1:0]  colour_q, colour_d;
  logic                    result_valid_q, result_valid_d;
  logic                    no_signal_q, no_signal_d;
  logic [CNT_W-1:0]        sample_q, sample_d;
  logic [1:0]              sample_filter_q, sample_filter_d;
  logic                    sample_valid_q, sample_valid_d;

  logic                    fall;
  logic                    tmr_tc;
  logic [CNT_W-1:0]        win_sample;
  logic [CNT_W-1:0]        lo_v, hi_v;
  logic [VOTE_W-1:0]       best_v;
  logic [IDX_W-1:0]        best_idx;

  assign fall   = prev_q & ~sync_q[1];
  assign tmr_tc = (tmr_q == '0);

  // Two-flop synchroniser for the sensor output plus one delay stage for edges.
  always_comb begin
    sync_d = {sync_q[0], colour_freq};
    prev_d = sync_q[1];
  end

  // Winner search: strict compare keeps the lowest index on ties.
  always_comb begin
    best_v   = vote_q[0];
    best_idx = '0;
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (vote_q[c] > best_v) begin
        best_v   = vote_q[c];
        best_idx = IDX_W'(c);
      end
    end
  end

  // Sequencer next-state plus width counter, voting and result datapath.
  always_comb begin
    state_d         = state_q;
    f_d             = f_q;
    round_d         = round_q;
    tmr_d           = tmr_q;
    cnt_d           = cnt_q;
    latch_d         = latch_q;
    fall_seen_d     = fall_seen_q;
    miss_d          = miss_q;
    vote_d          = vote_q;
    colour_d        = colour_q;
    result_valid_d  = 1'b0;
    no_signal_d     = no_signal_q;
    sample_d        = sample_q;
    sample_filter_d = sample_filter_q;
    sample_valid_d  = 1'b0;
    win_sample      = '0;
    lo_v            = '0;
    hi_v            = '0;

    if (!en) begin
      // Abort: discard the frame but keep the last published decision.
      state_d     = IDLE;
      f_d         = 2'd0;
      round_d     = '0;
      tmr_d       = '0;
      cnt_d       = '0;
      latch_d     = '0;
      fall_seen_d = 1'b0;
      miss_d      = 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) vote_d[c] = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = SETTLE;
          f_d         = 2'd0;
          round_d     = '0;
          tmr_d       = SETTLE_LOAD;
          cnt_d       = '0;
          latch_d     = '0;
          fall_seen_d = 1'b0;
        end
        SETTLE: begin
          if (tmr_tc) begin
            state_d = MEASURE;
            tmr_d   = WIN_LOAD;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        MEASURE: begin
          if (fall) begin
            latch_d     = cnt_q;
            cnt_d       = '0;
            fall_seen_d = 1'b1;
          end else if (sync_q[1] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end

          if (tmr_tc) begin
            // Window end: the edge landing in this last cycle still counts.
            win_sample = fall_seen_d ? latch_d : '0;
            if (!fall_seen_d) miss_d = 1'b1;
            for (int c = 0; c < NUM_CLASSES; c++) begin
              lo_v = thr_lo[(c * 4 + int'(f_q)) * CNT_W +: CNT_W];
              hi_v = thr_hi[(c * 4 + int'(f_q)) * CNT_W +: CNT_W];
              if ((lo_v < win_sample) && (win_sample < hi_v))
                vote_d[c] = vote_q[c] + VOTE_W'(1);
            end
            sample_d        = win_sample;
            sample_filter_d = f_q;
            sample_valid_d  = 1'b1;

            if ((f_q == 2'd3) && (round_q == LAST_ROUND)) begin
              state_d = DECIDE;
            end else begin
              state_d     = SETTLE;
              f_d         = f_q + 2'd1;
              if (f_q == 2'd3) round_d = round_q + RND_W'(1);
              tmr_d       = SETTLE_LOAD;
              cnt_d       = '0;
              latch_d     = '0;
              fall_seen_d = 1'b0;
            end
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        DECIDE: begin
          colour_d = '0;
          if (best_v >= MATCH_V) colour_d[best_idx] = 1'b1;
          no_signal_d    = miss_q;
          result_valid_d = 1'b1;
          miss_d         = 1'b0;
          for (int c = 0; c < NUM_CLASSES; c++) vote_d[c] = '0;
          state_d     = SETTLE;
          f_d         = 2'd0;
          round_d     = '0;
          tmr_d       = SETTLE_LOAD;
          cnt_d       = '0;
          latch_d     = '0;
          fall_seen_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end

    // Filter selects follow the filter index being entered.
    s2_d = (f_d == 2'd1) || (f_d == 2'd2);
    s3_d = (f_d == 2'd1) || (f_d == 2'd3);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      f_q             <= 2'd0;
      round_q         <= '0;
      tmr_q           <= '0;
      sync_q          <= 2'b00;
      prev_q          <= 1'b0;
      cnt_q           <= '0;
      latch_q         <= '0;
      fall_seen_q     <= 1'b0;
      miss_q          <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) vote_q[c] <= '0;
      s2_q            <= 1'b0;
      s3_q            <= 1'b0;
      colour_q        <= '0;
      result_valid_q  <= 1'b0;
      no_signal_q     <= 1'b0;
      sample_q        <= '0;
      sample_filter_q <= 2'd0;
      sample_valid_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      f_q             <= f_d;
      round_q         <= round_d;
      tmr_q           <= tmr_d;
      sync_q          <= sync_d;
      prev_q          <= prev_d;
      cnt_q           <= cnt_d;
      latch_q         <= latch_d;
      fall_seen_q     <= fall_seen_d;
      miss_q          <= miss_d;
      vote_q          <= vote_d;
      s2_q            <= s2_d;
      s3_q            <= s3_d;
      colour_q        <= colour_d;
      result_valid_q  <= result_valid_d;
      no_signal_q     <= no_signal_d;
      sample_q        <= sample_d;
      sample_filter_q <= sample_filter_d;
      sample_valid_q  <= sample_valid_d;
    end
  end

  assign s2            = s2_q;
  assign s3            = s3_q;
  assign colour        = colour_q;
  assign result_valid  = result_valid_q;
  assign no_signal     = no_signal_q;
  assign sample        = sample_q;
  assign sample_filter = sample_filter_q;
  assign sample_valid  = sample_valid_q;

endmodule

// File: tb/tb_colour_classifier.sv
// Bench for colour_classifier: square-wave sensor model, expected decisions
// queued when a frame is started and compared when result_valid appears.
module tb_colour_classifier;

  localparam int CNT_W = 12;
  localparam int NCL   = 3;

  logic                    clk;
  logic                    rst_n;
  logic                    en;
  logic                    colour_freq;
  logic [NCL*4*CNT_W-1:0]  thr_lo;
  logic [NCL*4*CNT_W-1:0]  thr_hi;
  logic                    s2, s3;
  logic [NCL-1:0]          colour;
  logic                    result_valid;
  logic                    no_signal;
  logic [CNT_W-1:0]        sample;
  logic [1:0]              sample_filter;
  logic                    sample_valid;

  colour_classifier #(
    .CNT_W(CNT_W), .WIN_CYCLES(200), .SETTLE_CYCLES(10),
    .ROUNDS(2), .NUM_CLASSES(NCL), .MATCH_MIN(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .colour_freq(colour_freq),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .s2(s2), .s3(s3),
    .colour(colour), .result_valid(result_valid), .no_signal(no_signal),
    .sample(sample), .sample_filter(sample_filter), .sample_valid(sample_valid)
  );

  typedef struct {
    logic [NCL-1:0] colour;
    logic           nosig;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   hp       = 30;
  int   ph       = 0;
  bit   dead     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sensor model: hp cycles high, hp cycles low, or stuck high when dead.
  initial begin
    colour_freq = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (dead) colour_freq = 1'b1;
      else begin
        ph++;
        if (ph >= hp) begin
          ph = 0;
          colour_freq = ~colour_freq;
        end
      end
    end
  end

  function automatic logic [1:0] fmap(input int f);
    case (f)
      0: return 2'b00;
      1: return 2'b11;
      2: return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  task automatic set_class(input int c, input int lo, input int hi);
    for (int f = 0; f < 4; f++) begin
      thr_lo[(c*4+f)*CNT_W +: CNT_W] = CNT_W'(lo);
      thr_hi[(c*4+f)*CNT_W +: CNT_W] = CNT_W'(hi);
    end
  endtask

  task automatic stop_and_setup(input int width, input bit is_dead);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    hp   = width;
    dead = is_dead;
    @(posedge clk);
    #1;
  endtask

  // Waits for result_valid, tallying sample stream deviations on the way.
  task automatic wait_result(input int budget, input logic [CNT_W-1:0] exp_samp,
                             output int lat, output bit tmo,
                             output logic [NCL-1:0] col, output logic nsig,
                             output int nsv, output int bad_samp, output int bad_filt);
    lat = 0; tmo = 1'b1; col = '0; nsig = 1'b0;
    nsv = 0; bad_samp = 0; bad_filt = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sample_valid) begin
        if (sample !== exp_samp) bad_samp++;
        if (sample_filter !== 2'(nsv % 4)) bad_filt++;
        if ((nsv % 4) != 3 && {s2, s3} !== fmap(nsv % 4 + 1)) bad_filt++;
        nsv++;
      end
      if (result_valid) begin
        lat = i; tmo = 1'b0; col = colour; nsig = no_signal;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; thr_lo = '0; thr_hi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s2, s3, colour, result_valid, no_signal, sample_valid} !== 8'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got s2s3=%b%b colour=%b rv=%b ns=%b sv=%b required all 0",
               s2, s3, colour, result_valid, no_signal, sample_valid);
    end
    checks++;
    if (sample !== '0 || sample_filter !== 2'b00) begin
      failures++;
      $display("FAIL reset_sample: got sample=%0d filter=%0d required 0/0", sample, sample_filter);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs one frame already started by the caller and checks it against the queue head.
  task automatic check_frame(input string name, input int budget, input logic [CNT_W-1:0] exp_samp);
    int lat, nsv, bs, bf; bit tmo; logic [NCL-1:0] col; logic nsig; exp_t e;
    wait_result(budget, exp_samp, lat, tmo, col, nsig, nsv, bs, bf);
    e = sb.pop_front();
    checks++;
    if (tmo) begin
      failures++;
      $display("FAIL %s_timeout: got no result_valid within %0d cycles required one", name, budget);
    end
    checks++;
    if (lat != e.lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, e.lat);
    end
    checks++;
    if (col !== e.colour) begin
      failures++;
      $display("FAIL %s_colour: got %b required %b", name, col, e.colour);
    end
    checks++;
    if (nsig !== e.nosig) begin
      failures++;
      $display("FAIL %s_no_signal: got %b required %b", name, nsig, e.nosig);
    end
    checks++;
    if (nsv != 8 || bs != 0) begin
      failures++;
      $display("FAIL %s_samples: got %0d windows with %0d bad samples required 8 windows of %0d",
               name, nsv, bs, exp_samp);
    end
    checks++;
    if (bf != 0) begin
      failures++;
      $display("FAIL %s_filter_seq: got %0d filter/select errors required 0", name, bf);
    end
  endtask

  task automatic test_red;
    stop_and_setup(30, 1'b0);
    set_class(0, 25, 35); set_class(1, 100, 110); set_class(2, 100, 110);
    en = 1'b1;
    sb.push_back('{3'b001, 1'b0, 1682});
    check_frame("red_first", 2000, 12'd30);
    sb.push_back('{3'b001, 1'b0, 1681});
    check_frame("red_second", 2000, 12'd30);
  endtask

  task automatic test_boundary;
    stop_and_setup(35, 1'b0);
    set_class(0, 25, 35); set_class(1, 100, 110); set_class(2, 100, 110);
    en = 1'b1;
    sb.push_back('{3'b000, 1'b0, 1682});
    check_frame("boundary", 2000, 12'd35);
  endtask

  task automatic test_dead;
    stop_and_setup(30, 1'b1);
    set_class(0, 25, 35); set_class(1, 100, 110); set_class(2, 100, 110);
    en = 1'b1;
    sb.push_back('{3'b000, 1'b1, 1682});
    check_frame("dead", 2000, 12'd0);
  endtask

  task automatic test_tie;
    stop_and_setup(30, 1'b0);
    dead = 1'b0;
    set_class(0, 25, 35); set_class(1, 100, 110); set_class(2, 25, 35);
    en = 1'b1;
    sb.push_back('{3'b001, 1'b0, 1682});
    check_frame("tie", 2000, 12'd30);
  endtask

  task automatic test_abort;
    int early_rv;
    stop_and_setup(30, 1'b0);
    set_class(0, 25, 35); set_class(1, 100, 110); set_class(2, 100, 110);
    en = 1'b1;
    early_rv = 0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) early_rv++;
      if (i == 500) en = 1'b0;
    end
    checks++;
    if (early_rv != 0) begin
      failures++;
      $display("FAIL abort_no_result: got %0d result_valid pulses required 0", early_rv);
    end
    checks++;
    if (colour !== 3'b001) begin
      failures++;
      $display("FAIL abort_colour_hold: got %b required 001", colour);
    end
    set_class(0, 100, 110); set_class(1, 25, 35);
    en = 1'b1;
    sb.push_back('{3'b010, 1'b0, 1682});
    check_frame("abort_next", 2000, 12'd30);
  endtask

  task automatic test_async_reset;
    stop_and_setup(30, 1'b0);
    en = 1'b1;
    repeat (300) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s2, s3} !== 2'b00) begin
      failures++;
      $display("FAIL async_s2s3: got %b%b required 00", s2, s3);
    end
    checks++;
    if (colour !== '0 || result_valid !== 1'b0 || no_signal !== 1'b0) begin
      failures++;
      $display("FAIL async_result: got colour=%b rv=%b ns=%b required 000/0/0",
               colour, result_valid, no_signal);
    end
    checks++;
    if (sample !== '0 || sample_filter !== 2'b00 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_sample: got sample=%0d filter=%0d sv=%b required 0/0/0",
               sample, sample_filter, sample_valid);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    sb.push_back('{3'b010, 1'b0, 1682});
    check_frame("after_reset", 2000, 12'd30);
  endtask

  initial begin
    test_reset();
    test_red();
    test_boundary();
    test_dead();
    test_tie();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
